// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller: NS/EW green-yellow-allred sequencing with
// pedestrian green truncation (minimum-green guarded) and a night flash mode.
//
// state    | meaning
// ---------+-----------------------------------------------
// ALLRED_A | clearance before NS green
// NS_G     | NS green, EW red
// NS_Y     | NS yellow, EW red
// ALLRED_B | clearance before EW green
// EW_G     | EW green, NS red
// EW_Y     | EW yellow, NS red
// FLASH    | both roads blink yellow at T_FLASH half-period

module traffic_light_ctrl #(
    parameter int CNT_W       = 4,
    parameter int T_GREEN     = 8,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 2,
    parameter int T_MIN_GREEN = 3,
    parameter int T_FLASH     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ped_req,
    input  logic             flash_en,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic [CNT_W-1:0] count,
    output logic [2:0]       state,
    output logic             ped_ack
);

    typedef enum logic [2:0] {
        ALLRED_A = 3'd0,
        NS_G     = 3'd1,
        NS_Y     = 3'd2,
        ALLRED_B = 3'd3,
        EW_G     = 3'd4,
        EW_Y     = 3'd5,
        FLASH    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] LD_FLASH  = CNT_W'(T_FLASH - 1);
    // Once count falls to this value, green has run for T_MIN_GREEN cycles.
    localparam logic [CNT_W-1:0] GREEN_CUT = CNT_W'(T_GREEN - T_MIN_GREEN);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    state_t           state_r, state_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;
    logic             pend_r, pend_nxt;
    logic             ack_r, ack_nxt;
    logic             fbit_r, fbit_nxt;
    logic             pend_eff;
    logic             cnt_zero;
    logic             green_exit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ALLRED_A;
            cnt_r   <= LD_ALLRED;
            pend_r  <= 1'b0;
            ack_r   <= 1'b0;
            fbit_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            pend_r  <= pend_nxt;
            ack_r   <= ack_nxt;
            fbit_r  <= fbit_nxt;
        end
    end

    // A request arriving on the exit edge is serviced by that same exit.
    assign pend_eff   = pend_r | ped_req;
    assign cnt_zero   = (cnt_r == '0);
    assign green_exit = cnt_zero || (pend_eff && (cnt_r <= GREEN_CUT));

    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r - 1'b1;
        pend_nxt  = pend_eff;
        ack_nxt   = 1'b0;
        fbit_nxt  = fbit_r;

        if (flash_en) begin
            pend_nxt = 1'b0;
            if (state_r != FLASH) begin
                state_nxt = FLASH;
                cnt_nxt   = LD_FLASH;
                fbit_nxt  = 1'b1;
            end else if (cnt_zero) begin
                cnt_nxt  = LD_FLASH;
                fbit_nxt = ~fbit_r;
            end
        end else begin
            case (state_r)
                ALLRED_A: begin
                    if (cnt_zero) begin
                        state_nxt = NS_G;
                        cnt_nxt   = LD_GREEN;
                    end
                end
                NS_G: begin
                    if (green_exit) begin
                        state_nxt = NS_Y;
                        cnt_nxt   = LD_YELLOW;
                        if (pend_eff) begin
                            ack_nxt  = 1'b1;
                            pend_nxt = 1'b0;
                        end
                    end
                end
                NS_Y: begin
                    if (cnt_zero) begin
                        state_nxt = ALLRED_B;
                        cnt_nxt   = LD_ALLRED;
                    end
                end
                ALLRED_B: begin
                    if (cnt_zero) begin
                        state_nxt = EW_G;
                        cnt_nxt   = LD_GREEN;
                    end
                end
                EW_G: begin
                    if (green_exit) begin
                        state_nxt = EW_Y;
                        cnt_nxt   = LD_YELLOW;
                        if (pend_eff) begin
                            ack_nxt  = 1'b1;
                            pend_nxt = 1'b0;
                        end
                    end
                end
                EW_Y: begin
                    if (cnt_zero) begin
                        state_nxt = ALLRED_A;
                        cnt_nxt   = LD_ALLRED;
                    end
                end
                FLASH: begin
                    state_nxt = ALLRED_A;
                    cnt_nxt   = LD_ALLRED;
                    pend_nxt  = 1'b0;
                    fbit_nxt  = 1'b0;
                end
                default: begin
                    state_nxt = ALLRED_A;
                    cnt_nxt   = LD_ALLRED;
                    pend_nxt  = 1'b0;
                    fbit_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ns_light = LAMP_R;
        ew_light = LAMP_R;
        case (state_r)
            NS_G:    ns_light = LAMP_G;
            NS_Y:    ns_light = LAMP_Y;
            EW_G:    ew_light = LAMP_G;
            EW_Y:    ew_light = LAMP_Y;
            FLASH: begin
                ns_light = {1'b0, fbit_r, 1'b0};
                ew_light = {1'b0, fbit_r, 1'b0};
            end
            default: begin
                ns_light = LAMP_R;
                ew_light = LAMP_R;
            end
        endcase
    end

    assign count   = cnt_r;
    assign state   = state_r;
    assign ped_ack = ack_r;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: normal cycle, pedestrian truncation,
// flash mode and asynchronous mid-phase reset, plus a per-cycle conflict monitor.

module tb_traffic_light_ctrl;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] O = 3'b000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ped_req = 1'b0;
    logic       flash_en = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [3:0] count;
    logic [2:0] state;
    logic       ped_ack;

    int errors = 0;
    int checks = 0;

    traffic_light_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ped_req  (ped_req),
        .flash_en (flash_en),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .count    (count),
        .state    (state),
        .ped_ack  (ped_ack)
    );

    always #5 clk = ~clk;

    // Outside FLASH, a road showing green/yellow requires the other to show red.
    always @(negedge clk) begin
        if (rst_n && state != 3'd6) begin
            checks++;
            assert (!((ns_light != R && ew_light != R) || ns_light === O || ew_light === O))
            else begin
                errors++;
                $error("FAIL conflict t=%0t observed ns=%b ew=%b st=%0d expected one road red", $time, ns_light, ew_light, state);
            end
        end
    end

    task automatic chk(input string tag, input logic [2:0] e_st, input logic [3:0] e_cnt,
                       input logic [2:0] e_ns, input logic [2:0] e_ew, input logic e_ack);
        checks++;
        assert ({state, count, ns_light, ew_light, ped_ack} === {e_st, e_cnt, e_ns, e_ew, e_ack})
        else begin
            errors++;
            $error("FAIL %s t=%0t observed st=%0d cnt=%0d ns=%b ew=%b ack=%b expected st=%0d cnt=%0d ns=%b ew=%b ack=%b",
                   tag, $time, state, count, ns_light, ew_light, ped_ack, e_st, e_cnt, e_ns, e_ew, e_ack);
        end
    endtask

    // Checks n consecutive cycles of one phase, count descending from start.
    task automatic run(input string tag, input logic [2:0] e_st, input int start, input int n,
                       input logic [2:0] e_ns, input logic [2:0] e_ew, input logic ack_first);
        for (int i = 0; i < n; i++) begin
            chk(tag, e_st, 4'(start - i), e_ns, e_ew, (i == 0) ? ack_first : 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset", 3'd0, 4'd1, R, R, 1'b0);

        // 1: plain cycle, 26-cycle period
        rst_n = 1'b1;
        run("s1_ara", 3'd0, 1, 2, R, R, 1'b0);
        run("s1_nsg", 3'd1, 7, 8, G, R, 1'b0);
        run("s1_nsy", 3'd2, 2, 3, Y, R, 1'b0);
        run("s1_arb", 3'd3, 1, 2, R, R, 1'b0);
        run("s1_ewg", 3'd4, 7, 8, R, G, 1'b0);
        run("s1_ewy", 3'd5, 2, 3, R, Y, 1'b0);
        run("s1_ara2", 3'd0, 1, 2, R, R, 1'b0);

        // 2: request on first NS_G cycle -> green 7,6,5
        ped_req = 1'b1;
        run("s2_nsg0", 3'd1, 7, 1, G, R, 1'b0);
        ped_req = 1'b0;
        run("s2_nsg", 3'd1, 6, 2, G, R, 1'b0);
        run("s2_nsy", 3'd2, 2, 3, Y, R, 1'b1);
        run("s2_arb", 3'd3, 1, 2, R, R, 1'b0);
        run("s2_ewg", 3'd4, 7, 8, R, G, 1'b0);
        run("s2_ewy", 3'd5, 2, 3, R, Y, 1'b0);
        run("s2_ara", 3'd0, 1, 2, R, R, 1'b0);

        // 3: request at count 2 -> green ends after 6 cycles
        run("s3_nsg", 3'd1, 7, 5, G, R, 1'b0);
        ped_req = 1'b1;
        run("s3_nsg2", 3'd1, 2, 1, G, R, 1'b0);
        ped_req = 1'b0;
        run("s3_nsy", 3'd2, 2, 3, Y, R, 1'b1);

        // 4: request during ALLRED_B held until EW_G, truncated to 3
        ped_req = 1'b1;
        run("s4_arb1", 3'd3, 1, 1, R, R, 1'b0);
        ped_req = 1'b0;
        run("s4_arb0", 3'd3, 0, 1, R, R, 1'b0);
        run("s4_ewg", 3'd4, 7, 3, R, G, 1'b0);
        run("s4_ewy", 3'd5, 2, 3, R, Y, 1'b1);
        run("s4_ara", 3'd0, 1, 2, R, R, 1'b0);
        run("s4_nsg", 3'd1, 7, 8, G, R, 1'b0);
        run("s4_nsy", 3'd2, 2, 3, Y, R, 1'b0);
        run("s4_arb", 3'd3, 1, 2, R, R, 1'b0);

        // 5: flash raised mid EW_G; ped_req during FLASH must be ignored
        run("s5_ewg", 3'd4, 7, 3, R, G, 1'b0);
        flash_en = 1'b1;
        run("s5_ewg4", 3'd4, 4, 1, R, G, 1'b0);
        ped_req = 1'b1;
        run("s5_fl_on", 3'd6, 3, 4, Y, Y, 1'b0);
        ped_req = 1'b0;
        run("s5_fl_off", 3'd6, 3, 4, O, O, 1'b0);
        run("s5_fl_on2", 3'd6, 3, 4, Y, Y, 1'b0);
        flash_en = 1'b0;
        run("s5_fl_last", 3'd6, 3, 1, O, O, 1'b0);
        run("s5_ara", 3'd0, 1, 2, R, R, 1'b0);
        run("s5_nsg", 3'd1, 7, 8, G, R, 1'b0);
        run("s5_nsy", 3'd2, 2, 1, Y, R, 1'b0);

        // 6: short async reset pulse mid NS_Y
        #2 rst_n = 1'b0;
        #1 chk("s6_async", 3'd0, 4'd1, R, R, 1'b0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        run("s6_ara", 3'd0, 0, 1, R, R, 1'b0);
        run("s6_nsg", 3'd1, 7, 8, G, R, 1'b0);
        run("s6_nsy", 3'd2, 2, 3, Y, R, 1'b0);
        run("s6_arb", 3'd3, 1, 2, R, R, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Parametrised two-road intersection controller; successor to the fixed two-light signal block.
- Sequences north-south (NS) and east-west (EW) through green, yellow and all-red phases with programmable durations and a down-counter.
- Adds a pedestrian request that truncates green, with a minimum-green guarantee.
- Adds a night flash mode: both roads blink yellow.

Parameters:
CNT_W, 4, width of phase down-counter and count output
T_GREEN, 8, green phase length in cycles
T_YELLOW, 3, yellow phase length in cycles
T_ALLRED, 2, all-red clearance length in cycles
T_MIN_GREEN, 3, minimum green cycles before pedestrian truncation; must satisfy 1 <= T_MIN_GREEN <= T_GREEN
T_FLASH, 4, flash half-period in cycles
Rule: all T_* >= 1 and each T_* - 1 must fit in CNT_W bits.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ped_req  input  1  pedestrian request; level or pulse, sampled each clock
flash_en  input  1  flash-mode request; level
ns_light  output  3  NS lamps {red,yellow,green}
ew_light  output  3  EW lamps {red,yellow,green}
count  output  CNT_W  cycles remaining in current phase (0 = last cycle)
state  output  3  FSM state code
ped_ack  output  1  one-cycle pulse when a pending request is serviced

Behaviour:
State codes:
- ALLRED_A = 0
- NS_G = 1
- NS_Y = 2
- ALLRED_B = 3
- EW_G = 4
- EW_Y = 5
- FLASH = 6

Reset (rst_n low, asynchronous):
- state = ALLRED_A, count = T_ALLRED-1.
- Both lights = 3'b100.
- ped_pend = 0, ped_ack = 0, flash phase bit = 0.

Normal sequence:
- Order: ALLRED_A -> NS_G -> NS_Y -> ALLRED_B -> EW_G -> EW_Y -> ALLRED_A.
- Entering a phase loads count = T_phase-1.
- count decrements once per cycle.
- The phase is left on the edge where count == 0.
- Full cycle = 2*(T_GREEN+T_YELLOW+T_ALLRED) cycles.

Lamp decode (from registered state only; no input-to-output combinational path):
- NS_G: ns = 001, ew = 100.
- NS_Y: ns = 010, ew = 100.
- EW_G: ns = 100, ew = 001.
- EW_Y: ns = 100, ew = 010.
- ALLRED_*: both = 100.
- FLASH: both = {0, flash phase bit, 0}.

Pedestrian request:
- ped_req = 1 in any non-FLASH state sets ped_pend.
- In NS_G or EW_G with ped_pend = 1, green exits when count == 0 OR count <= T_GREEN-T_MIN_GREEN.
  - Green therefore lasts at least T_MIN_GREEN cycles and never more than T_GREEN.
- On the green-exit edge with ped_pend = 1:
  - ped_ack pulses high for exactly one cycle, coinciding with the first yellow cycle.
  - ped_pend clears.
- ped_req asserted on that same edge is dropped (already serviced).
- Requests in yellow or all-red stay pending until the next green.
- Multiple requests before service collapse into one ack.

Flash mode:
- flash_en = 1 forces state = FLASH on the next edge from any state. It has priority over phase expiry and pedestrian truncation.
- On entry: count = T_FLASH-1, flash bit = 1, ped_pend cleared.
- In FLASH, when count == 0, the flash bit toggles and count reloads T_FLASH-1.
- ped_req is ignored in FLASH.
- flash_en = 0 while in FLASH exits to ALLRED_A with count = T_ALLRED-1. The sequence restarts at NS_G.
- If flash_en drops and rises in consecutive cycles, the controller re-enters FLASH after one ALLRED_A cycle.

Other rules:
- Reset mid-phase returns immediately to the reset values above.
- Conflicting greens (both roads green, or any road green/yellow while the other is not red) are never allowed. Verification asserts this every cycle.
- Illegal state codes (7) recover to ALLRED_A on the next edge.

Test Plan:
1. Reset, then release rst_n with no requests -> 2 cycles ALLRED_A, NS_G 8 cycles (count 7..0), NS_Y 3, ALLRED_B 2, EW_G 8, EW_Y 3, ALLRED_A 2; period 26 cycles; never both roads non-red.
2. ped_req pulse on the first NS_G cycle -> NS_G lasts exactly 3 cycles (count 7,6,5); ped_ack high for one cycle on the first NS_Y cycle; next EW_G lasts full 8.
3. ped_req on the 6th NS_G cycle (count = 2) -> immediate exit on the next edge after min-green is satisfied (green total 6 cycles); single ped_ack.
4. ped_req during ALLRED_B -> held pending; EW_G truncated to 3 cycles; ped_ack at first EW_Y cycle; ped_req during FLASH -> no ack afterwards.
5. flash_en raised mid EW_G -> next cycle state 6, both lights 010 for 4 cycles, 000 for 4, repeating; drop flash_en -> ALLRED_A 2 cycles, then NS_G.
6. rst_n pulled low mid NS_Y for less than one clock period -> outputs go to reset values asynchronously; sequence restarts as in scenario 1.
